// File: rtl/dm_arbiter_if.sv
// ---------------------------------------------------------------------------
// dm_arbiter_if
// Bundle of requester-side and memory-side signals for dm_arbiter.
//
//   req, wr, lock      per-requester request, access type (1=write), keep-grant hint
//   addr, wdata        packed per-requester address / write data
//   gnt, rvalid        one-hot grant pulse / one-hot read-data-valid pulse
//   rdata              shared read data, meaningful only while rvalid is non-zero
//   mem_addr/_wdata/_wr  data memory request
//   mem_rdata          data memory read data (synchronous, one cycle after address)
//
// Modports: slave  = the arbiter
//           master = the environment (requesters plus data memory)
// ---------------------------------------------------------------------------
interface dm_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        wr;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_wr;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req, wr, lock, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_wr
  );

  modport master (
    output req, wr, lock, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
// Round-robin arbiter granting NUM_REQ requesters access to one synchronous
// data memory. Three-state FSM: IDLE -> ACCESS (one cycle, gnt + memory
// strobe) -> RESP (rvalid for reads, arbitration for the next access).
// Back-to-back traffic therefore sustains one access every two cycles.
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   dm_arbiter_if.slave (requester and memory signals)
//
// Optional feature: define DM_ARB_LOCK_EN to let the requester that just
// finished keep the next grant while it holds both lock and req in RESP.
// Without the macro the lock input is ignored.
// ---------------------------------------------------------------------------
module dm_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
) (
  input logic         clk,
  input logic         rst,
  dm_arbiter_if.slave bus
);

  localparam int WIN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state;
  logic [WIN_W-1:0]   last_winner;
  logic               wr_latched;

  logic [WIN_W-1:0]   rr_winner;
  logic               rr_found;
  logic [WIN_W:0]     cand;
  logic [WIN_W-1:0]   next_winner;
  logic               arb_valid;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_wr;

  // Round-robin search starting one past the last winner. cand is one bit
  // wider so last_winner + k cannot overflow before the wrap.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    rr_winner = last_winner;
    rr_found  = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_winner} + (WIN_W+1)'(k);
      if (cand >= (WIN_W+1)'(NUM_REQ)) cand = cand - (WIN_W+1)'(NUM_REQ);
      if (!rr_found && bus.req[cand[WIN_W-1:0]]) begin
        rr_found  = 1'b1;
        rr_winner = cand[WIN_W-1:0];
      end
    end
  end

`ifdef DM_ARB_LOCK_EN
  // In RESP last_winner is the requester just served; a held lock+req pins it.
  always_comb begin
    next_winner = rr_winner;
    arb_valid   = rr_found;
    if (state == RESP && bus.lock[last_winner] && bus.req[last_winner]) begin
      next_winner = last_winner;
      arb_valid   = 1'b1;
    end
  end
`else
  always_comb begin
    next_winner = rr_winner;
    arb_valid   = rr_found;
  end

  logic lock_unused;
  assign lock_unused = ^bus.lock;
`endif

  // Select the winner's request fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (next_winner == WIN_W'(i)) begin
        sel_addr  = bus.addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
        sel_wr    = bus.wr[i];
      end
    end
  end

  // FSM with registered outputs: gnt/mem_* are loaded on the edge entering
  // ACCESS, rvalid on the edge entering RESP, and both pulses self-clear.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_winner   <= WIN_W'(NUM_REQ - 1);
      wr_latched    <= 1'b0;
      bus.gnt       <= '0;
      bus.rvalid    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wr    <= 1'b0;
    end else begin
      bus.gnt    <= '0;
      bus.rvalid <= '0;
      bus.mem_wr <= 1'b0;
      unique case (state)
        IDLE, RESP: begin
          if (arb_valid) begin
            state         <= ACCESS;
            last_winner   <= next_winner;
            wr_latched    <= sel_wr;
            bus.gnt       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << next_winner;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            bus.mem_wr    <= sel_wr;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= RESP;
          // gnt still holds the winner's one-hot code during ACCESS.
          bus.rvalid <= wr_latched ? '0 : bus.gnt;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory data arrives during RESP, so it is passed straight through,
  // gated to zero whenever no rvalid bit is up.
  assign bus.rdata = (|bus.rvalid) ? bus.mem_rdata : '0;

endmodule
